// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - five-stage pipeline hazard controller: forwarding, load-use stall, branch flush
// Optional saturating stall/flush performance counters: HAZARD_PERF_EN
module hazard_ctrl #(
    parameter int REG_ADDR_W   = 3,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic [REG_ADDR_W-1:0] ex_rs1,
    input  logic [REG_ADDR_W-1:0] ex_rs2,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_memread,
    input  logic [REG_ADDR_W-1:0] mem_rd,
    input  logic                  mem_regwrite,
    input  logic [REG_ADDR_W-1:0] wb_rd,
    input  logic                  wb_regwrite,
    input  logic                  branch_taken,
    output logic [1:0]            forwardA,
    output logic [1:0]            forwardB,
    output logic                  pc_stall,
    output logic                  ifid_stall,
    output logic                  idex_bubble,
    output logic                  flush,
    output logic [7:0]            stall_count,
    output logic [7:0]            flush_count
);

    localparam logic [1:0] RUN     = 2'd0;
    localparam logic [1:0] LU_HOLD = 2'd1;
    localparam logic [1:0] FLUSH   = 2'd2;
    localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);

    logic [1:0] state, state_nxt;
    logic [2:0] flush_cnt, flush_cnt_nxt;
    logic       lu;
    logic       stall;
    logic       flush_enter;

    // EX/MEM result is newer than WB data, so it wins when both match
    always_comb begin
        forwardA = 2'b00;
        if (mem_regwrite && mem_rd != '0 && mem_rd == ex_rs1)
            forwardA = 2'b10;
        else if (wb_regwrite && wb_rd != '0 && wb_rd == ex_rs1)
            forwardA = 2'b01;
    end

    always_comb begin
        forwardB = 2'b00;
        if (mem_regwrite && mem_rd != '0 && mem_rd == ex_rs2)
            forwardB = 2'b10;
        else if (wb_regwrite && wb_rd != '0 && wb_rd == ex_rs2)
            forwardB = 2'b01;
    end

    assign lu = ex_memread && ex_rd != '0 && (ex_rd == id_rs1 || ex_rd == id_rs2);

    always_comb begin
        state_nxt     = state;
        flush_cnt_nxt = flush_cnt;
        stall         = 1'b0;
        flush_enter   = 1'b0;
        case (state)
            RUN: begin
                if (branch_taken) begin
                    state_nxt     = FLUSH;
                    flush_cnt_nxt = FLUSH_LOAD;
                    flush_enter   = 1'b1;
                end else if (lu) begin
                    stall     = 1'b1;
                    state_nxt = LU_HOLD;
                end
            end
            LU_HOLD: begin
                if (branch_taken) begin
                    state_nxt     = FLUSH;
                    flush_cnt_nxt = FLUSH_LOAD;
                    flush_enter   = 1'b1;
                end else begin
                    state_nxt = RUN;
                end
            end
            FLUSH: begin
                if (flush_cnt == 3'd0)
                    state_nxt = RUN;
                else
                    flush_cnt_nxt = flush_cnt - 3'd1;
            end
            default: state_nxt = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= RUN;
            flush_cnt <= 3'd0;
        end else begin
            state     <= state_nxt;
            flush_cnt <= flush_cnt_nxt;
        end
    end

    assign pc_stall    = stall;
    assign ifid_stall  = stall;
    assign idex_bubble = stall;
    assign flush       = (state == FLUSH);

`ifdef HAZARD_PERF_EN
    logic [7:0] stall_count_q;
    logic [7:0] flush_count_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_count_q <= 8'h00;
            flush_count_q <= 8'h00;
        end else begin
            if (stall && stall_count_q != 8'hFF)
                stall_count_q <= stall_count_q + 8'h01;
            if (flush_enter && flush_count_q != 8'hFF)
                flush_count_q <= flush_count_q + 8'h01;
        end
    end

    assign stall_count = stall_count_q;
    assign flush_count = flush_count_q;
`else
    logic perf_unused;
    assign perf_unused = flush_enter;
    assign stall_count = 8'h00;
    assign flush_count = 8'h00;
`endif

endmodule
